// File: rtl/mat_inst_fetch.sv
// Instruction prefetch stage: walks the PC through instruction memory and buffers
// {word, pc} pairs in a small FIFO in front of the matrix control unit.
module mat_inst_fetch #(
    parameter int INST_MEM_ADDR_SIZE  = 32,
    parameter int INST_MEM_WIDTH_SIZE = 128,
    parameter int QUEUE_DEPTH         = 4
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           start,
    input  logic [INST_MEM_ADDR_SIZE-1:0]  start_pc,
    input  logic                           stop,
    input  logic                           redirect,
    input  logic [INST_MEM_ADDR_SIZE-1:0]  redirect_pc,
    output logic [INST_MEM_ADDR_SIZE-1:0]  inst_mem_read_addr,
    input  logic [INST_MEM_WIDTH_SIZE-1:0] inst_mem_data_out,
    output logic                           inst_valid,
    input  logic                           inst_ready,
    output logic [INST_MEM_WIDTH_SIZE-1:0] inst,
    output logic [INST_MEM_ADDR_SIZE-1:0]  inst_pc,
    output logic                           busy
);
    localparam int PTR_W = $clog2(QUEUE_DEPTH);
    localparam int CNT_W = $clog2(QUEUE_DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(QUEUE_DEPTH);

    typedef enum logic {IDLE, RUN} state_t;

    typedef struct packed {
        logic [INST_MEM_WIDTH_SIZE-1:0] word;
        logic [INST_MEM_ADDR_SIZE-1:0]  pc;
    } entry_t;

    state_t                        state, state_nxt;
    logic [INST_MEM_ADDR_SIZE-1:0] pc, pc_nxt;
    entry_t [QUEUE_DEPTH-1:0]      storage;
    logic [PTR_W-1:0]              head, tail;
    logic [CNT_W-1:0]              count;
    logic                          flush, enq, deq;

    assign inst_valid         = (count != '0);
    assign inst               = storage[head].word;
    assign inst_pc            = storage[head].pc;
    assign inst_mem_read_addr = pc;
    assign busy               = (state == RUN);

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        flush     = 1'b0;
        enq       = 1'b0;
        deq       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = RUN;
                    pc_nxt    = start_pc;
                    flush     = 1'b1;
                end
            end
            RUN: begin
                if (stop) begin
                    state_nxt = IDLE;
                    flush     = 1'b1;
                end else if (redirect) begin
                    pc_nxt = redirect_pc;
                    flush  = 1'b1;
                end else begin
                    // A full queue still accepts a word when the head leaves this cycle.
                    deq = inst_valid & inst_ready;
                    enq = (count != FULL_CNT) | deq;
                    if (enq) pc_nxt = pc + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            pc    <= '0;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (enq) tail <= tail + 1'b1;
            if (deq) head <= head + 1'b1;
            count <= count + CNT_W'(enq) - CNT_W'(deq);
        end
    end

    // Storage is not cleared on flush; head/count alone decide what is visible.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            storage <= '0;
        end else if (enq) begin
            storage[tail] <= '{word: inst_mem_data_out, pc: pc};
        end
    end

endmodule

// File: tb/tb_mat_inst_fetch.sv
// Randomized bench for mat_inst_fetch against a queue-based model of the prefetch stage.
module tb_mat_inst_fetch;
    localparam int AW    = 32;
    localparam int DW    = 128;
    localparam int DEPTH = 4;

    logic          clock = 1'b0;
    logic          reset;
    logic          start, stop, redirect, inst_ready;
    logic [AW-1:0] start_pc, redirect_pc;
    logic [AW-1:0] inst_mem_read_addr;
    logic [DW-1:0] inst_mem_data_out;
    logic          inst_valid, busy;
    logic [DW-1:0] inst;
    logic [AW-1:0] inst_pc;

    int n_chk  = 0;
    int n_fail = 0;

    // model state
    logic          m_run;
    logic [AW-1:0] m_pc;
    logic [AW-1:0] mq[$];

    always #5 clock = ~clock;

    function automatic logic [DW-1:0] mem_word(logic [AW-1:0] a);
        return {a ^ 32'hDEAD_BEEF, ~a, a + 32'h0101_0101, a * 32'd7};
    endfunction

    assign inst_mem_data_out = mem_word(inst_mem_read_addr);

    mat_inst_fetch #(
        .INST_MEM_ADDR_SIZE (AW),
        .INST_MEM_WIDTH_SIZE(DW),
        .QUEUE_DEPTH        (DEPTH)
    ) dut (
        .clock             (clock),
        .reset             (reset),
        .start             (start),
        .start_pc          (start_pc),
        .stop              (stop),
        .redirect          (redirect),
        .redirect_pc       (redirect_pc),
        .inst_mem_read_addr(inst_mem_read_addr),
        .inst_mem_data_out (inst_mem_data_out),
        .inst_valid        (inst_valid),
        .inst_ready        (inst_ready),
        .inst              (inst),
        .inst_pc           (inst_pc),
        .busy              (busy)
    );

    task automatic chk(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic check_outputs();
        chk("busy", DW'(busy), DW'(m_run));
        chk("read_addr", DW'(inst_mem_read_addr), DW'(m_pc));
        chk("valid", DW'(inst_valid), DW'(mq.size() != 0));
        if (mq.size() != 0) begin
            chk("inst_pc", DW'(inst_pc), DW'(mq[0]));
            chk("inst", inst, mem_word(mq[0]));
        end
    endtask

    task automatic model_reset();
        m_run = 1'b0;
        m_pc  = '0;
        mq.delete();
    endtask

    // Called at a falling edge: check, drive, advance model and DUT one cycle.
    task automatic step(input logic st, input logic [AW-1:0] spc, input logic sp,
                        input logic rd, input logic [AW-1:0] rpc, input logic rdy);
        check_outputs();
        start = st; start_pc = spc; stop = sp;
        redirect = rd; redirect_pc = rpc; inst_ready = rdy;
        if (!m_run) begin
            if (st) begin
                m_run = 1'b1;
                m_pc  = spc;
                mq.delete();
            end
        end else if (sp) begin
            m_run = 1'b0;
            mq.delete();
        end else if (rd) begin
            mq.delete();
            m_pc = rpc;
        end else begin
            if (rdy && mq.size() != 0) void'(mq.pop_front());
            if (mq.size() < DEPTH) begin
                mq.push_back(m_pc);
                m_pc = m_pc + 1;
            end
        end
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic idle_step(input logic rdy);
        step(1'b0, '0, 1'b0, 1'b0, '0, rdy);
    endtask

    initial begin
        reset = 1'b0;
        start = 1'b0; stop = 1'b0; redirect = 1'b0; inst_ready = 1'b0;
        start_pc = '0; redirect_pc = '0;
        model_reset();
        repeat (2) @(negedge clock);
        check_outputs();
        chk("rst_inst", inst, '0);
        chk("rst_inst_pc", DW'(inst_pc), '0);
        reset = 1'b1;
        @(negedge clock);

        // Streaming from 0 with the consumer always ready.
        step(1'b1, 32'h0, 1'b0, 1'b0, '0, 1'b1);
        repeat (10) idle_step(1'b1);
        step(1'b0, '0, 1'b1, 1'b0, '0, 1'b1);
        idle_step(1'b1);

        // Back-pressure: queue fills and PC freezes at 4, then drains in order.
        step(1'b1, 32'h0, 1'b0, 1'b0, '0, 1'b0);
        repeat (6) idle_step(1'b0);
        chk("full_addr_frozen", DW'(inst_mem_read_addr), DW'(32'd4));
        chk("full_head_pc", DW'(inst_pc), '0);
        repeat (3) idle_step(1'b1);
        idle_step(1'b0);
        // queue now holds pcs 3..6 after one stalled refill; step to 5..8
        repeat (2) idle_step(1'b1);
        repeat (2) idle_step(1'b0);
        step(1'b0, '0, 1'b0, 1'b1, 32'h40, 1'b1);
        chk("redir_valid_low", DW'(inst_valid), '0);
        chk("redir_addr", DW'(inst_mem_read_addr), DW'(32'h40));
        idle_step(1'b1);
        chk("redir_first_pc", DW'(inst_pc), DW'(32'h40));
        repeat (4) idle_step(1'b1);

        // stop together with redirect: stop wins, PC not reloaded.
        step(1'b0, '0, 1'b1, 1'b1, 32'h99, 1'b1);
        chk("stop_redir_idle", DW'(busy), '0);
        idle_step(1'b1);

        // PC wrap-around.
        step(1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, '0, 1'b1);
        repeat (6) idle_step(1'b1);
        step(1'b0, '0, 1'b1, 1'b0, '0, 1'b1);

        // Async reset mid-RUN with three queued entries.
        step(1'b1, 32'h100, 1'b0, 1'b0, '0, 1'b0);
        repeat (3) idle_step(1'b0);
        check_outputs();
        #2 reset = 1'b0;
        #1;
        chk("arst_valid", DW'(inst_valid), '0);
        chk("arst_busy", DW'(busy), '0);
        chk("arst_addr", DW'(inst_mem_read_addr), '0);
        model_reset();
        @(negedge clock);
        reset = 1'b1;
        repeat (4) idle_step(1'b1);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            logic          st, sp, rd, rdy;
            logic [AW-1:0] spc, rpc;
            st  = ($urandom_range(0, 3) == 0);
            sp  = ($urandom_range(0, 39) == 0);
            rd  = ($urandom_range(0, 14) == 0);
            rdy = ($urandom_range(0, 2) != 0);
            spc = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFC + $urandom_range(0, 3) : $urandom;
            rpc = $urandom;
            step(st, spc, sp, rd, rpc, rdy);
        end
        check_outputs();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
